// File: rtl/imm_decode_unit_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | imm_decode_unit_if : instruction-in / immediate-out handshake bundle        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface imm_decode_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | imm_decode_unit : buffered RISC-V immediate decoder with DEPTH-entry FIFO  |
// | Option macro IMMDEC_CSR_EN enables SYSTEM (CSR) immediate decode.          |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module imm_decode_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    imm_decode_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] c_TYPE_I    = 3'b000;
    localparam logic [2:0] c_TYPE_S    = 3'b001;
    localparam logic [2:0] c_TYPE_B    = 3'b010;
    localparam logic [2:0] c_TYPE_J    = 3'b011;
    localparam logic [2:0] c_TYPE_U    = 3'b100;
    localparam logic [2:0] c_TYPE_Z    = 3'b101;
    localparam logic [2:0] c_TYPE_NONE = 3'b110;
    localparam logic [2:0] c_TYPE_ILL  = 3'b111;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] r_imm_mem  [DEPTH];
    logic [2:0]      r_type_mem [DEPTH];
    logic            r_ill_mem  [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_type;
    logic            w_dec_ill;
    logic [31:0]     w_i;

    assign w_i     = bus.instr;
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // flush wins over both sides of the handshake
    assign w_push  = bus.in_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & bus.out_ready & ~flush;

    always_comb begin
        w_dec_imm  = '0;
        w_dec_type = c_TYPE_NONE;
        w_dec_ill  = 1'b0;
        case (w_i[6:0])
            c_OP_LOAD, c_OP_IMM, c_OP_JALR: begin
                w_dec_type = c_TYPE_I;
                w_dec_imm  = {{(XLEN-12){w_i[31]}}, w_i[31:20]};
            end
            c_OP_STORE: begin
                w_dec_type = c_TYPE_S;
                w_dec_imm  = {{(XLEN-12){w_i[31]}}, w_i[31:25], w_i[11:7]};
            end
            c_OP_BRANCH: begin
                w_dec_type = c_TYPE_B;
                w_dec_imm  = {{(XLEN-13){w_i[31]}}, w_i[31], w_i[7],
                              w_i[30:25], w_i[11:8], 1'b0};
            end
            c_OP_JAL: begin
                w_dec_type = c_TYPE_J;
                w_dec_imm  = {{(XLEN-21){w_i[31]}}, w_i[31], w_i[19:12],
                              w_i[20], w_i[30:21], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_dec_type = c_TYPE_U;
                w_dec_imm  = {{(XLEN-32){w_i[31]}}, w_i[31:12], 12'b0};
            end
            c_OP_REG: begin
                w_dec_type = c_TYPE_NONE;
            end
`ifdef IMMDEC_CSR_EN
            c_OP_SYSTEM: begin
                // funct3[2] selects the uimm (rs1 field) CSR forms
                if (w_i[14]) begin
                    w_dec_type = c_TYPE_Z;
                    w_dec_imm  = {{(XLEN-5){1'b0}}, w_i[19:15]};
                end else begin
                    w_dec_type = c_TYPE_I;
                    w_dec_imm  = {{(XLEN-12){w_i[31]}}, w_i[31:20]};
                end
            end
`endif
            default: begin
                w_dec_type = c_TYPE_ILL;
                w_dec_ill  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_imm_mem[k]  <= '0;
                r_type_mem[k] <= '0;
                r_ill_mem[k]  <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_imm_mem[r_wr_ptr]  <= w_dec_imm;
                r_type_mem[r_wr_ptr] <= w_dec_type;
                r_ill_mem[r_wr_ptr]  <= w_dec_ill;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.out_valid   = ~w_empty;
    assign bus.out_imm     = w_empty ? '0   : r_imm_mem[r_rd_ptr];
    assign bus.out_type    = w_empty ? 3'b0 : r_type_mem[r_rd_ptr];
    assign bus.out_illegal = w_empty ? 1'b0 : r_ill_mem[r_rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_imm_decode_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_imm_decode_unit : scoreboard bench for imm_decode_unit                  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_imm_decode_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    imm_decode_unit_if #(.XLEN(XLEN)) bus ();

    imm_decode_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
        logic signed [XLEN-1:0] r;
        r = $signed(v);
        return r;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares head entry whenever the DUT will pop it on the next edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got type %0h imm %0h, expected nothing",
                             bus.out_type, bus.out_imm);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_imm !== e.imm || bus.out_type !== e.typ || bus.out_illegal !== e.ill) begin
                        errors++;
                        $display("FAIL entry: got type %0h imm %0h ill %0b, expected type %0h imm %0h ill %0b",
                                 bus.out_type, bus.out_imm, bus.out_illegal, e.typ, e.imm, e.ill);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] w, input logic [31:0] imm32, input logic [2:0] t, input logic il);
        int n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.imm = (t == 3'b101) ? XLEN'(imm32) : sx32(imm32);
            e.typ = t;
            e.ill = il;
            exp_q.push_back(e);
            @(posedge clk); #1;
            chk("latency_out_valid", XLEN'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int n;
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", XLEN'(bus.out_valid), 0);
        chk("rst_in_ready", XLEN'(bus.in_ready), 1);
        chk("rst_out_imm", bus.out_imm, 0);
        chk("rst_out_type", XLEN'(bus.out_type), 0);
        chk("rst_out_illegal", XLEN'(bus.out_illegal), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Streamed directed vectors
        send(32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0); // addi x1,x0,-1
        send(32'hFE112E23, 32'hFFFFFFFC, 3'b001, 1'b0); // sw x1,-4(x2)
        send(32'h123452B7, 32'h12345000, 3'b100, 1'b0); // lui x5,0x12345
        send(32'hFE000CE3, 32'hFFFFFFF8, 3'b010, 1'b0); // beq x0,x0,-8
        send(32'h001000EF, 32'h00000800, 3'b011, 1'b0); // jal x1,+2048
        send(32'h80000197, 32'h80000000, 3'b100, 1'b0); // auipc x3,0x80000
        send(32'h7FF0A103, 32'h000007FF, 3'b000, 1'b0); // lw x2,2047(x1)
        send(32'h002081B3, 32'h00000000, 3'b110, 1'b0); // add
        send(32'h0000007F, 32'h00000000, 3'b111, 1'b1); // unsupported opcode

        // Fill, hold, then drain
        repeat (3) @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h00100093, 32'h00000001, 3'b000, 1'b0);
        send(32'h00200113, 32'h00000002, 3'b000, 1'b0);
        chk("full_in_ready", XLEN'(bus.in_ready), 0);
        fork
            send(32'h00300193, 32'h00000003, 3'b000, 1'b0);
            begin
                repeat (3) @(posedge clk); #1;
                chk("held_in_ready", XLEN'(bus.in_ready), 0);
                bus.out_ready = 1'b1;
                chk("full_pop_in_ready", XLEN'(bus.in_ready), 0);
                @(posedge clk); #1;
                chk("after_pop_in_ready", XLEN'(bus.in_ready), 1);
            end
        join
        repeat (4) @(posedge clk); #1;

        // Flush with one entry queued and a concurrent push
        bus.out_ready = 1'b0;
        send(32'h00500293, 32'h00000005, 3'b000, 1'b0);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00600313;
        flush        = 1'b1;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", XLEN'(bus.out_valid), 0);
        chk("flush_in_ready", XLEN'(bus.in_ready), 1);
        chk("empty_out_imm", bus.out_imm, 0);
        bus.out_ready = 1'b1;
        send(32'h00700393, 32'h00000007, 3'b000, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset with two entries queued
        bus.out_ready = 1'b0;
        send(32'h00800413, 32'h00000008, 3'b000, 1'b0);
        send(32'h00900493, 32'h00000009, 3'b000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", XLEN'(bus.out_valid), 0);
        chk("midrst_in_ready", XLEN'(bus.in_ready), 1);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // SYSTEM opcode, build dependent
`ifdef IMMDEC_CSR_EN
        send(32'h3002D0F3, 32'h00000005, 3'b101, 1'b0); // csrrwi x1,0x300,5
        send(32'h30009073, 32'h00000300, 3'b000, 1'b0); // csrrw x0,0x300,x1
`else
        send(32'h3002D0F3, 32'h00000000, 3'b111, 1'b1);
        send(32'h30009073, 32'h00000000, 3'b111, 1'b1);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_remaining", XLEN'(exp_q.size()), 0);
        chk("final_out_valid", XLEN'(bus.out_valid), 0);
        chk("final_out_type", XLEN'(bus.out_type), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
